dram_cmd_scheduler: RTL and testbench

//  Sequences DRAM commands for the controller: accepts one L2-derived access (bank/row/col, rd/wr),

---
 rtl/dram_cmd_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// Single-access DRAM command sequencer: open-row tracking, ACTIVATE on miss, periodic REFRESH.
// States: IDLE wait | ACT_HS/ACT_REL activate | RW_HS/RW_REL read-write | REF_HS/REF_REL refresh
module dram_cmd_scheduler #(
  parameter int  NUM_OF_BANKS     = 8,
  parameter int  NUM_OF_ROWS      = 128,
  parameter int  NUM_OF_COLS      = 8,
  parameter int  REFRESH_INTERVAL = 1024,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS),
  localparam int TW = $clog2(REFRESH_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  output logic          cmd_req,
  input  logic          cmd_ack,
  output logic [1:0]    cmd,
  output logic [BW-1:0] bank_id,
  output logic [RW-1:0] row_id,
  output logic [CW-1:0] col_id,
  output logic          bank_rw,
  output logic          done,
  output logic          busy,
  output logic          ref_overrun
);

  typedef enum logic [2:0] {IDLE, ACT_HS, ACT_REL, RW_HS, RW_REL, REF_HS, REF_REL} state_t;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_REF = 2'b11;

  state_t              state_q, state_d;
  logic                cmd_req_q, cmd_req_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [BW-1:0]       bank_id_q, bank_id_d;
  logic [RW-1:0]       row_id_q, row_id_d;
  logic [CW-1:0]       col_id_q, col_id_d;
  logic                bank_rw_q, bank_rw_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;
  logic                pend_q, pend_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                lat_rw_q, lat_rw_d;
  logic [BW-1:0]       lat_bank_q, lat_bank_d;
  logic [RW-1:0]       lat_row_q, lat_row_d;
  logic [CW-1:0]       lat_col_q, lat_col_d;
  logic [NUM_OF_BANKS-1:0] valid_q, valid_d;
  logic [RW-1:0]       open_row_q [NUM_OF_BANKS];
  logic [RW-1:0]       open_row_d [NUM_OF_BANKS];

  logic ref_expire;
  logic hit;

  assign ref_expire = (cnt_q == TW'(REFRESH_INTERVAL - 1));
  assign hit        = valid_q[req_bank] && (open_row_q[req_bank] == req_row);
  assign req_ready  = (state_q == IDLE) && !pend_q && !ref_expire;

  assign cmd_req     = cmd_req_q;
  assign cmd         = cmd_q;
  assign bank_id     = bank_id_q;
  assign row_id      = row_id_q;
  assign col_id      = col_id_q;
  assign bank_rw     = bank_rw_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign ref_overrun = ovr_q;

  always_comb begin
    state_d    = state_q;
    cmd_req_d  = cmd_req_q;
    cmd_d      = cmd_q;
    bank_id_d  = bank_id_q;
    row_id_d   = row_id_q;
    col_id_d   = col_id_q;
    bank_rw_d  = bank_rw_q;
    done_d     = 1'b0;
    lat_rw_d   = lat_rw_q;
    lat_bank_d = lat_bank_q;
    lat_row_d  = lat_row_q;
    lat_col_d  = lat_col_q;
    valid_d    = valid_q;
    open_row_d = open_row_q;

    // cmd_req is only raised while cmd_ack is seen low; a late-falling ack delays the rise
    unique case (state_q)
      IDLE: begin
        if (pend_q || ref_expire) begin
          state_d   = REF_HS;
          cmd_req_d = !cmd_ack;
          cmd_d     = CMD_REF;
          bank_id_d = '0;
          row_id_d  = '0;
          col_id_d  = '0;
          bank_rw_d = 1'b0;
        end else if (req_valid) begin
          lat_rw_d   = req_rw;
          lat_bank_d = req_bank;
          lat_row_d  = req_row;
          lat_col_d  = req_col;
          bank_id_d  = req_bank;
          row_id_d   = req_row;
          cmd_req_d  = !cmd_ack;
          if (hit) begin
            state_d   = RW_HS;
            cmd_d     = req_rw ? CMD_WR : CMD_RD;
            col_id_d  = req_col;
            bank_rw_d = req_rw;
          end else begin
            state_d   = ACT_HS;
            cmd_d     = CMD_ACT;
            col_id_d  = '0;
            bank_rw_d = 1'b0;
          end
        end
      end
      ACT_HS: begin
        if (cmd_req_q && cmd_ack) begin
          state_d   = ACT_REL;
          cmd_req_d = 1'b0;
        end else if (!cmd_req_q && !cmd_ack) begin
          cmd_req_d = 1'b1;
        end
      end
      ACT_REL: begin
        if (!cmd_ack) begin
          valid_d[lat_bank_q]    = 1'b1;
          open_row_d[lat_bank_q] = lat_row_q;
          state_d   = RW_HS;
          cmd_req_d = 1'b1;
          cmd_d     = lat_rw_q ? CMD_WR : CMD_RD;
          col_id_d  = lat_col_q;
          bank_rw_d = lat_rw_q;
        end
      end
      RW_HS: begin
        if (cmd_req_q && cmd_ack) begin
          state_d   = RW_REL;
          cmd_req_d = 1'b0;
        end else if (!cmd_req_q && !cmd_ack) begin
          cmd_req_d = 1'b1;
        end
      end
      RW_REL: begin
        if (!cmd_ack) begin
          done_d    = 1'b1;
          state_d   = IDLE;
          bank_rw_d = 1'b0;
        end
      end
      REF_HS: begin
        if (cmd_req_q && cmd_ack) begin
          state_d   = REF_REL;
          cmd_req_d = 1'b0;
        end else if (!cmd_req_q && !cmd_ack) begin
          cmd_req_d = 1'b1;
        end
      end
      REF_REL: begin
        if (!cmd_ack) begin
          valid_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    cnt_d  = ref_expire ? '0 : cnt_q + TW'(1);
    ovr_d  = ovr_q | (ref_expire & pend_q);
    if (state_q == IDLE && state_d == REF_HS) pend_d = 1'b0;
    else if (ref_expire)                       pend_d = 1'b1;
    else                                       pend_d = pend_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cmd_req_q  <= 1'b0;
      cmd_q      <= CMD_ACT;
      bank_id_q  <= '0;
      row_id_q   <= '0;
      col_id_q   <= '0;
      bank_rw_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      lat_rw_q   <= 1'b0;
      lat_bank_q <= '0;
      lat_row_q  <= '0;
      lat_col_q  <= '0;
      valid_q    <= '0;
      open_row_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      bank_id_q  <= bank_id_d;
      row_id_q   <= row_id_d;
      col_id_q   <= col_id_d;
      bank_rw_q  <= bank_rw_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      lat_rw_q   <= lat_rw_d;
      lat_bank_q <= lat_bank_d;
      lat_row_q  <= lat_row_d;
      lat_col_q  <= lat_col_d;
      valid_q    <= valid_d;
      open_row_q <= open_row_d;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler; a one-cycle registered ack responder plays the DRAM side.
module tb_dram_cmd_scheduler;
  localparam int RI = 1024;
  localparam int BUDGET = 6000;
  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_REF = 2'b11;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       req_valid, req_ready, req_rw;
  logic [2:0] req_bank;
  logic [6:0] req_row;
  logic [2:0] req_col;
  logic       cmd_req, cmd_ack;
  logic [1:0] cmd;
  logic [2:0] bank_id;
  logic [6:0] row_id;
  logic [2:0] col_id;
  logic       bank_rw, done, busy, ref_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic hold = 1'b0;

  always #5 clk = ~clk;

  dram_cmd_scheduler #(.REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .bank_rw(bank_rw), .done(done), .busy(busy), .ref_overrun(ref_overrun)
  );

  // DRAM side: ack follows cmd_req one clock later unless frozen by hold
  always @(posedge clk or negedge rst_b)
    if (!rst_b)     cmd_ack <= 1'b0;
    else if (!hold) cmd_ack <= cmd_req;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic logic [15:0] enc(input logic rw, input logic [1:0] c, input logic [2:0] b,
                                      input logic [6:0] r, input logic [2:0] co);
    return {rw, c, b, r, co};
  endfunction

  logic [15:0] log_q[$];
  int   done_cnt = 0;
  int   bad_rw = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (cmd_req && !prev_req) log_q.push_back(enc(bank_rw, cmd, bank_id, row_id, col_id));
    prev_req = cmd_req;
    if (done) done_cnt++;
    if (cmd_req && (bank_rw != (cmd == C_WR))) bad_rw++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [2:0] b, input logic [6:0] r,
                       input logic [2:0] c, output int acc);
    int n = 0;
    req_valid = 1'b1; req_rw = rw; req_bank = b; req_row = r; req_col = c;
    while (!req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n >= BUDGET), 0);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int acc, output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < BUDGET);
    chk("done_timeout", 32'(n >= BUDGET), 0);
    lat = cyc - acc + 1;
  endtask

  task automatic do_access(input logic rw, input logic [2:0] b, input logic [6:0] r,
                           input logic [2:0] c, output int lat);
    int acc;
    issue(rw, b, r, c, acc);
    wait_done(acc, lat);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, lat, d0, n;
    req_valid = 1'b0; req_rw = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    #2 rst_b = 1'b0;
    #20;
    chk("rst_cmd_req", cmd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ref_overrun, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_ids", {bank_id, row_id, col_id}, 0);
    chk("rst_bank_rw", bank_rw, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk) rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // write miss: ACT then WRITE
    log_q.delete(); d0 = done_cnt;
    do_access(1'b1, 3'd2, 7'd5, 3'd3, lat);
    chk("wr_ncmd", log_q.size(), 2);
    chk("wr_act", log_q[0], enc(1'b0, C_ACT, 3'd2, 7'd5, 3'd0));
    chk("wr_write", log_q[1], enc(1'b1, C_WR, 3'd2, 7'd5, 3'd3));
    chk("wr_done", done_cnt - d0, 1);
    chk("wr_lat", lat, 9);

    // read hit on the open row
    log_q.delete(); d0 = done_cnt;
    do_access(1'b0, 3'd2, 7'd5, 3'd7, lat);
    chk("hit_ncmd", log_q.size(), 1);
    chk("hit_read", log_q[0], enc(1'b0, C_RD, 3'd2, 7'd5, 3'd7));
    chk("hit_done", done_cnt - d0, 1);
    chk("hit_lat", lat, 5);

    // different row in same bank
    log_q.delete();
    do_access(1'b0, 3'd2, 7'd6, 3'd1, lat);
    chk("miss6_ncmd", log_q.size(), 2);
    chk("miss6_act", log_q[0], enc(1'b0, C_ACT, 3'd2, 7'd6, 3'd0));
    chk("miss6_read", log_q[1], enc(1'b0, C_RD, 3'd2, 7'd6, 3'd1));
    chk("miss6_lat", lat, 9);

    // row 5 was closed by activating row 6
    log_q.delete();
    do_access(1'b1, 3'd2, 7'd5, 3'd0, lat);
    chk("miss5_ncmd", log_q.size(), 2);
    chk("miss5_act", log_q[0], enc(1'b0, C_ACT, 3'd2, 7'd5, 3'd0));
    chk("miss5_write", log_q[1], enc(1'b1, C_WR, 3'd2, 7'd5, 3'd0));

    // leave row 6 open before the refresh
    log_q.delete();
    do_access(1'b0, 3'd2, 7'd6, 3'd2, lat);
    chk("reopen6_act", log_q[0], enc(1'b0, C_ACT, 3'd2, 7'd6, 3'd0));

    // refresh beats a pending request, then closes row 6
    n = 0;
    while (cyc != RI - 1 && n < 3 * RI) begin
      @(negedge clk);
      n++;
    end
    chk("ref_wait_timeout", 32'(n >= 3 * RI), 0);
    chk("ref_ready_low", req_ready, 0);
    log_q.delete(); d0 = done_cnt;
    do_access(1'b0, 3'd2, 7'd6, 3'd4, lat);
    chk("ref_ncmd", log_q.size(), 3);
    chk("ref_first", log_q[0], enc(1'b0, C_REF, 3'd0, 7'd0, 3'd0));
    chk("ref_then_act", log_q[1], enc(1'b0, C_ACT, 3'd2, 7'd6, 3'd0));
    chk("ref_then_read", log_q[2], enc(1'b0, C_RD, 3'd2, 7'd6, 3'd4));
    chk("ref_done", done_cnt - d0, 1);
    chk("ref_acc_lat", lat, 9);

    // stall the handshake across two refresh intervals
    log_q.delete(); d0 = done_cnt;
    chk("ovr_before", ref_overrun, 0);
    hold = 1'b1;
    issue(1'b1, 3'd3, 7'd9, 3'd2, acc);
    repeat (2 * RI) @(negedge clk);
    chk("ovr_set", ref_overrun, 1);
    chk("ovr_busy", busy, 1);
    chk("ovr_req_held", cmd_req, 1);
    hold = 1'b0;
    wait_done(acc, lat);
    repeat (20) @(negedge clk);
    chk("ovr_ncmd", log_q.size(), 3);
    chk("ovr_act", log_q[0], enc(1'b0, C_ACT, 3'd3, 7'd9, 3'd0));
    chk("ovr_write", log_q[1], enc(1'b1, C_WR, 3'd3, 7'd9, 3'd2));
    chk("ovr_one_ref", log_q[2], enc(1'b0, C_REF, 3'd0, 7'd0, 3'd0));
    chk("ovr_done", done_cnt - d0, 1);
    chk("ovr_sticky", ref_overrun, 1);
    chk("ovr_idle", busy, 0);

    // reset during ACT_HS aborts silently and forgets open rows
    do_access(1'b0, 3'd4, 7'd1, 3'd0, lat);
    chk("open41_lat", lat, 9);
    log_q.delete(); d0 = done_cnt;
    issue(1'b0, 3'd4, 7'd2, 3'd5, acc);
    chk("ract_req", cmd_req, 1);
    chk("ract_cmd", cmd, C_ACT);
    rst_b = 1'b0;
    #1;
    chk("rrst_req", cmd_req, 0);
    chk("rrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("rrst_no_done", done_cnt - d0, 0);
    chk("rrst_ovr_clr", ref_overrun, 0);
    log_q.delete();
    do_access(1'b0, 3'd4, 7'd1, 3'd3, lat);
    chk("rrst_ncmd", log_q.size(), 2);
    chk("rrst_act", log_q[0], enc(1'b0, C_ACT, 3'd4, 7'd1, 3'd0));
    chk("rrst_read", log_q[1], enc(1'b0, C_RD, 3'd4, 7'd1, 3'd3));
    chk("rrst_lat", lat, 9);

    chk("bank_rw_consistency", bad_rw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
